cache_fill_fsm: RTL
===================

Name: cache_fill_fsm

Overview:
- Miss-handling controller between the single-cycle CPU's instruction/data caches and the multi-cycle pipelined main memory.
- On a cache miss it stalls the CPU and issues one read per word of the missing block.
- It writes each returned word into the cache data array, then writes the tag on the final word.
- One instance serves each cache. The CPU holds its PC and register/flag writes while fsm_busy is high.

Parameters:
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; power of 2, at least 2.
- ADDR_W, 16, byte-address width.
- DATA_W, 16, memory word width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- miss_detected  input  1  cache lookup missed this cycle.
- miss_address  input  ADDR_W  byte address that missed.
- fsm_busy  output  1  stall request to the CPU.
- memory_read_req  output  1  one read request to memory this cycle.
- memory_address  output  ADDR_W  byte address of the current request.
- memory_data  input  DATA_W  returned read data.
- memory_data_valid  input  1  memory_data is valid this cycle.
- write_data_array  output  1  write fill_data into the cache data array.
- write_tag_array  output  1  write the tag/valid bit for the block at fill_address.
- fill_address  output  ADDR_W  byte address of the word being written.
- fill_data  output  DATA_W  equals memory_data (pass-through).

Behaviour:
- Widths: WB = log2(WORDS_PER_BLOCK); OFF = WB+1 (byte offset bits).
  - base = miss_address with its low OFF bits cleared (0xFFF0 mask at defaults).
  - base is captured in a register when a miss is accepted.
- States: IDLE, FILL. Counters: issue_cnt and rx_cnt, each WB+1 bits.
- Reset (async, rst_n=0):
  - state=IDLE, counters=0, base=0.
  - All outputs 0, except fill_data, which follows memory_data.
  - Reset mid-fill abandons the fill. No further writes occur; the cache block is left untagged.
- IDLE:
  - fsm_busy = miss_detected (combinational), so the CPU stalls in the same cycle as the miss.
  - On miss_detected: capture base, clear both counters, go to FILL next edge.
  - memory_data_valid is ignored. No array writes occur.
- FILL:
  - fsm_busy = 1.
  - Issue:
    - memory_read_req = (issue_cnt < WORDS_PER_BLOCK).
    - memory_address = base + 2*issue_cnt.
    - issue_cnt increments on each request.
    - Result: exactly WORDS_PER_BLOCK consecutive request cycles, starting on the first FILL cycle.
  - Receive: on memory_data_valid with rx_cnt < WORDS_PER_BLOCK:
    - write_data_array=1, fill_address = base + 2*rx_cnt, rx_cnt increments.
  - Completion:
    - On the valid where rx_cnt == WORDS_PER_BLOCK-1, also assert write_tag_array=1 with the same fill_address.
    - Go to IDLE next edge. fsm_busy drops in that IDLE cycle unless a new miss is present.
  - The FSM is latency-agnostic. It counts valids and never assumes a fixed memory latency.
  - Valids arriving after the final word, or while in IDLE, are ignored.
- miss_detected while in FILL: ignored. The CPU is stalled, so any reassertion is a re-lookup of the same address.
- Back-to-back misses: the cycle after completion is IDLE. A miss present then is accepted immediately, with no dead cycle beyond that one IDLE cycle.
- Address arithmetic is modulo 2^ADDR_W. A block at 0xFFF0 fills 0xFFF0 through 0xFFFE with no carry out.
- memory_address and fill_address are 0 whenever the corresponding request or write strobe is low.

Decomposition:
- Shared package:
  - State enum {IDLE, FILL}.
  - Constants WORDS_PER_BLOCK=8, BLOCK_OFF_BITS=4, MEM_LATENCY=4. MEM_LATENCY is used only by the memory model and benches.
- Natural sub-module: fill_counter, a (WB+1)-bit clear/increment counter with terminal-count flag.
  - Instantiated twice, once for issue and once for receive.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, no miss for 10 cycles -> all strobes 0, fsm_busy 0.
- Basic fill, miss_address=0x1236, memory latency 4:
  - fsm_busy high for 13 cycles starting in the miss cycle.
  - memory_address 0x1230 through 0x123E on 8 consecutive cycles.
  - 8 write_data_array pulses at 0x1230 through 0x123E.
  - write_tag_array exactly once, together with fill_address 0x123E.
- Irregular returns: memory_data_valid gaps of 0, 3 and 1 cycles between words -> rx ordering preserved, tag written only on the 8th valid, fsm_busy held until then.
- Wrap boundary: miss_address=0xFFFA -> requests 0xFFF0 through 0xFFFE, no carry; spurious valid in IDLE afterwards -> no write.
- Reset mid-fill: rst_n asserted after the 5th data word -> immediate IDLE, no write_tag_array. A new miss at 0x0040 then fills cleanly.
- Back-to-back: miss_detected held through completion with a new address 0x2000 in the IDLE cycle -> second fill starts at 0x2000. Misses asserted during FILL do not change base.

Source files
------------

// File: rtl/cache_fill_fsm_pkg.sv
// Shared types and constants for the cache miss/fill controller.
package cache_fill_fsm_pkg;

    // Controller states: waiting for a miss, or streaming a block in.
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    // Default block geometry: 8 sixteen-bit words = 16 bytes per block.
    localparam int WORDS_PER_BLOCK = 8;
    localparam int BLOCK_OFF_BITS  = 4;

    // Read latency of the main-memory model; the controller itself never uses it.
    localparam int MEM_LATENCY     = 4;

endpackage : cache_fill_fsm_pkg

// File: rtl/cache_fill_fsm_counter.sv
// Word counter used by the fill controller: synchronous clear, increment,
// and a flag that is high while the count equals TERMINAL.
module fill_counter #(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             at_terminal
);

    localparam logic [WIDTH-1:0] TERM_C = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Clear wins over increment so a newly accepted miss always starts at word 0.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count       = count_q;
    assign at_terminal = (count_q == TERM_C);

endmodule : fill_counter

// File: rtl/cache_fill_fsm.sv
// Cache miss controller: stalls the CPU on a miss, issues one memory read per
// word of the missing block, writes each returned word into the data array,
// and writes the tag together with the last word.
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    output logic              fsm_busy,
    output logic              memory_read_req,
    output logic [ADDR_W-1:0] memory_address,
    input  logic [DATA_W-1:0] memory_data,
    input  logic              memory_data_valid,
    output logic              write_data_array,
    output logic              write_tag_array,
    output logic [ADDR_W-1:0] fill_address,
    output logic [DATA_W-1:0] fill_data
);

    import cache_fill_fsm_pkg::*;

    // WB word-index bits, plus one bit for the byte within a 16-bit word.
    localparam int WB  = $clog2(WORDS_PER_BLOCK);
    localparam int OFF = WB + 1;
    localparam int CW  = WB + 1;

    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF) - 1);
    localparam logic [CW-1:0]     WPB_C    = CW'(WORDS_PER_BLOCK);

    fill_state_e       state_q;
    fill_state_e       state_d;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] base_d;

    logic [CW-1:0]     issue_cnt;
    logic [CW-1:0]     rx_cnt;
    logic              issue_done;
    logic              rx_at_last;
    logic              accept;
    logic              issue_fire;
    logic              rx_fire;

    // Requests issued so far; terminal count means every word has been requested.
    fill_counter #(
        .WIDTH    (CW),
        .TERMINAL (WORDS_PER_BLOCK)
    ) u_issue_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (accept),
        .inc         (issue_fire),
        .count       (issue_cnt),
        .at_terminal (issue_done)
    );

    // Words received so far; terminal flag marks the valid that carries the last word.
    fill_counter #(
        .WIDTH    (CW),
        .TERMINAL (WORDS_PER_BLOCK - 1)
    ) u_rx_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (accept),
        .inc         (rx_fire),
        .count       (rx_cnt),
        .at_terminal (rx_at_last)
    );

    // Next-state and output decode. Outputs default to 0 so the address buses
    // stay quiet whenever their strobe is low. The rst_n term keeps fsm_busy
    // low while reset is held even if the cache reports a miss.
    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        fsm_busy         = 1'b0;
        memory_read_req  = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        fill_address     = '0;
        accept           = 1'b0;
        issue_fire       = 1'b0;
        rx_fire          = 1'b0;

        case (state_q)
            IDLE: begin
                fsm_busy = miss_detected & rst_n;
                if (miss_detected && rst_n) begin
                    accept  = 1'b1;
                    base_d  = miss_address & ~OFF_MASK;
                    state_d = FILL;
                end
            end
            FILL: begin
                // Re-asserted misses here are re-lookups of the stalled address.
                fsm_busy = 1'b1;
                if (!issue_done) begin
                    issue_fire      = 1'b1;
                    memory_read_req = 1'b1;
                    memory_address  = base_q + (ADDR_W'(issue_cnt) << 1);
                end
                // Count valids rather than cycles, so any memory latency works.
                if (memory_data_valid && (rx_cnt < WPB_C)) begin
                    rx_fire          = 1'b1;
                    write_data_array = 1'b1;
                    fill_address     = base_q + (ADDR_W'(rx_cnt) << 1);
                    if (rx_at_last) begin
                        write_tag_array = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end
        endcase
    end

    // State and block-base registers; reset drops any fill in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

    // Returned data goes straight to the data array; only the strobe is gated.
    assign fill_data = memory_data;

endmodule : cache_fill_fsm
